// File: rtl/clk_counter_mod_if.sv
// Control/status bundle for clk_counter_mod.
// master: the block that drives the counter (the bench, or a controller).
// slave:  the counter itself.
// Handshake: there is no valid/ready pair. Every input is a level sampled on
// each rising clk edge, and every output is a registered level that is
// stable for the whole following cycle.
// With CLK_COUNTER_CAPTURE_EN defined, the bundle also carries capture/cap_value.
interface clk_counter_mod_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic [WIDTH-1:0] counter_out;
  logic             tc;
  logic             running;
  logic             done;
  logic [1:0]       dbg_state;
`ifdef CLK_COUNTER_CAPTURE_EN
  logic             capture;
  logic [WIDTH-1:0] cap_value;

  modport master (
    output en, up, load, load_value, start, capture,
    input  counter_out, tc, running, done, dbg_state, cap_value
  );
  modport slave (
    input  en, up, load, load_value, start, capture,
    output counter_out, tc, running, done, dbg_state, cap_value
  );
`else
  modport master (
    output en, up, load, load_value, start,
    input  counter_out, tc, running, done, dbg_state
  );
  modport slave (
    input  en, up, load, load_value, start,
    output counter_out, tc, running, done, dbg_state
  );
`endif
endinterface

// File: rtl/clk_counter_mod.sv
// Parametrised modulo up/down counter with load, terminal-count pulse and
// optional one-shot mode (IDLE/RUN/DONE FSM).
// Optional feature macro: CLK_COUNTER_CAPTURE_EN adds capture/cap_value.
// dbg_state exposes the FSM encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
module clk_counter_mod #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] MAX_VALUE = 32'hFFFF_FFFF,
  parameter int          ONE_SHOT  = 0
) (
  input  logic               clk,
  input  logic               neg_reset,
  clk_counter_mod_if.slave   ctrl_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W    = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_W   = '0;
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               OS       = (ONE_SHOT != 0);
  localparam state_t           RST_ST   = OS ? ST_IDLE : ST_RUN;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_clip;
  logic [WIDTH-1:0] reload;
  logic             at_term;

  // Clipped load value, restart value and terminal detect for the current direction
  always_comb begin
    load_clip = (ctrl_if.load_value > MAX_W) ? MAX_W : ctrl_if.load_value;
    reload    = ctrl_if.up ? ZERO_W : MAX_W;
    at_term   = ctrl_if.up ? (cnt_q == MAX_W) : (cnt_q == ZERO_W);
  end

  // Next-state and next-count: load > start (one-shot, not RUN) > enabled step > hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    if (ctrl_if.load) begin
      cnt_d = load_clip;
    end else if (OS && ctrl_if.start && (state_q != ST_RUN)) begin
      cnt_d   = reload;
      state_d = ST_RUN;
    end else if ((state_q == ST_RUN) && ctrl_if.en) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (OS) begin
          // One-shot parks on the terminal value instead of wrapping
          state_d = ST_DONE;
        end else begin
          cnt_d = reload;
        end
      end else if (ctrl_if.up) begin
        cnt_d = cnt_q + ONE_W;
      end else begin
        cnt_d = cnt_q - ONE_W;
      end
    end
  end

  // State, count and terminal-count registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!neg_reset) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
    end
  end

`ifdef CLK_COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;

  // Snapshot of the pre-update count whenever capture is sampled high
  always_ff @(posedge clk) begin
    if (!neg_reset) begin
      cap_q <= '0;
    end else if (ctrl_if.capture) begin
      cap_q <= cnt_q;
    end
  end

  assign ctrl_if.cap_value = cap_q;
`endif

  assign ctrl_if.counter_out = cnt_q;
  assign ctrl_if.tc          = tc_q;
  assign ctrl_if.running     = (state_q == ST_RUN);
  assign ctrl_if.done        = OS && (state_q == ST_DONE);
  assign ctrl_if.dbg_state   = state_q;

endmodule

// File: tb/tb_clk_counter_mod.sv
// Directed bench for clk_counter_mod: one free-running instance (WIDTH=4,
// MAX_VALUE=9) and one one-shot instance (WIDTH=4, MAX_VALUE=3).
module tb_clk_counter_mod;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  always #5 clk = ~clk;

  clk_counter_mod_if #(.WIDTH(4)) bus_a ();
  clk_counter_mod_if #(.WIDTH(4)) bus_b ();

  clk_counter_mod #(.WIDTH(4), .MAX_VALUE(32'd9), .ONE_SHOT(0)) dut_a (
    .clk       (clk),
    .neg_reset (rst_a_n),
    .ctrl_if   (bus_a.slave)
  );

  clk_counter_mod #(.WIDTH(4), .MAX_VALUE(32'd3), .ONE_SHOT(1)) dut_b (
    .clk       (clk),
    .neg_reset (rst_b_n),
    .ctrl_if   (bus_b.slave)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic       start;
    logic [3:0] exp_cnt;
    logic       exp_tc;
    logic       exp_run;
    logic       exp_done;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rst_n, input logic en, input logic up,
                              input logic load, input logic [3:0] lv, input logic start,
                              input logic [3:0] exp_cnt, input logic exp_tc,
                              input logic exp_run, input logic exp_done);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.up = up; v.load = load; v.lv = lv; v.start = start;
    v.exp_cnt = exp_cnt; v.exp_tc = exp_tc; v.exp_run = exp_run; v.exp_done = exp_done;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit sel_b, input vec_t v);
    if (!sel_b) begin
      rst_a_n = v.rst_n; bus_a.en = v.en; bus_a.up = v.up;
      bus_a.load = v.load; bus_a.load_value = v.lv; bus_a.start = v.start;
    end else begin
      rst_b_n = v.rst_n; bus_b.en = v.en; bus_b.up = v.up;
      bus_b.load = v.load; bus_b.load_value = v.lv; bus_b.start = v.start;
    end
  endtask

  task automatic apply(input bit sel_b, input vec_t v, input int idx);
    drive(sel_b, v);
    @(posedge clk);
    #1;
    if (!sel_b) begin
      check("a_cnt",  idx, 32'(bus_a.counter_out), 32'(v.exp_cnt));
      check("a_tc",   idx, 32'(bus_a.tc),          32'(v.exp_tc));
      check("a_run",  idx, 32'(bus_a.running),     32'(v.exp_run));
      check("a_done", idx, 32'(bus_a.done),        32'(v.exp_done));
    end else begin
      check("b_cnt",  idx, 32'(bus_b.counter_out), 32'(v.exp_cnt));
      check("b_tc",   idx, 32'(bus_b.tc),          32'(v.exp_tc));
      check("b_run",  idx, 32'(bus_b.running),     32'(v.exp_run));
      check("b_done", idx, 32'(bus_b.done),        32'(v.exp_done));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0] exp_cnt;
    logic       exp_tc;

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_value = '0; bus_a.start = 1'b0;
    bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.load_value = '0; bus_b.start = 1'b0;
`ifdef CLK_COUNTER_CAPTURE_EN
    bus_a.capture = 1'b1; bus_b.capture = 1'b0;
`endif

    // Free-running table: rst_n en up load lv start | cnt tc run done
    tbl_a.push_back(mk(1, 0, 1, 1,  2, 0,  2, 0, 1, 0)); // load 2
    tbl_a.push_back(mk(1, 1, 0, 0,  0, 0,  1, 0, 1, 0)); // down
    tbl_a.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0, 1, 0));
    tbl_a.push_back(mk(1, 1, 0, 0,  0, 0,  9, 1, 1, 0)); // 0 -> 9 with tc
    tbl_a.push_back(mk(1, 1, 1, 0,  0, 0,  0, 1, 1, 0)); // flip up at 9 -> 0 with tc
    tbl_a.push_back(mk(1, 1, 1, 0,  0, 0,  1, 0, 1, 0));
    tbl_a.push_back(mk(1, 1, 1, 1, 13, 0,  9, 0, 1, 0)); // clip, load beats en
    tbl_a.push_back(mk(1, 0, 1, 0,  0, 0,  9, 0, 1, 0)); // hold
    tbl_a.push_back(mk(1, 0, 1, 1, 15, 0,  9, 0, 1, 0)); // clip at top of range
    tbl_a.push_back(mk(1, 0, 1, 1,  0, 0,  0, 0, 1, 0));
    tbl_a.push_back(mk(1, 1, 0, 0,  0, 0,  9, 1, 1, 0)); // down wrap from loaded 0
    tbl_a.push_back(mk(1, 0, 1, 0,  0, 1,  9, 0, 1, 0)); // start ignored, hold
    tbl_a.push_back(mk(1, 1, 1, 0,  0, 1,  0, 1, 1, 0)); // start ignored, wrap
    tbl_a.push_back(mk(1, 0, 1, 1,  5, 0,  5, 0, 1, 0));
    tbl_a.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0, 1, 0)); // reset mid-count, en ignored
    tbl_a.push_back(mk(1, 1, 1, 0,  0, 0,  1, 0, 1, 0));
    tbl_a.push_back(mk(0, 1, 1, 1,  4, 0,  0, 0, 1, 0)); // reset beats load
    tbl_a.push_back(mk(1, 1, 0, 0,  0, 0,  9, 1, 1, 0));

    // One-shot table (MAX_VALUE=3)
    tbl_b.push_back(mk(0, 0, 1, 0,  0, 0,  0, 0, 0, 0)); // reset -> IDLE
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  0, 0, 0, 0)); // en in IDLE does nothing
    tbl_b.push_back(mk(1, 0, 1, 1,  2, 1,  2, 0, 0, 0)); // load beats start, stays IDLE
    tbl_b.push_back(mk(1, 0, 1, 0,  0, 1,  0, 0, 1, 0)); // start -> RUN at 0
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  1, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  2, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  3, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  3, 1, 0, 1)); // terminal: hold, DONE
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  3, 0, 0, 1)); // stays DONE
    tbl_b.push_back(mk(1, 0, 1, 0,  0, 1,  0, 0, 1, 0)); // restart
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 1,  1, 0, 1, 0)); // start in RUN ignored
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  2, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  3, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  3, 1, 0, 1));
    tbl_b.push_back(mk(1, 0, 0, 0,  0, 1,  3, 0, 1, 0)); // down restart from MAX
    tbl_b.push_back(mk(1, 1, 0, 0,  0, 0,  2, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 0, 0,  0, 0,  1, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 0, 0,  0, 0,  0, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 0, 0,  0, 0,  0, 1, 0, 1)); // down terminal holds 0
    tbl_b.push_back(mk(1, 0, 1, 0,  0, 1,  0, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  1, 0, 1, 0));
    tbl_b.push_back(mk(1, 1, 1, 1,  7, 0,  3, 0, 1, 0)); // clipped load in RUN
    tbl_b.push_back(mk(0, 1, 1, 0,  0, 1,  0, 0, 0, 0)); // reset mid-run -> IDLE
    tbl_b.push_back(mk(1, 1, 1, 0,  0, 0,  0, 0, 0, 0));

    // Reset values of both instances
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_a_cnt",  0, 32'(bus_a.counter_out), 0);
    check("rst_a_tc",   0, 32'(bus_a.tc),          0);
    check("rst_a_run",  0, 32'(bus_a.running),     1);
    check("rst_a_done", 0, 32'(bus_a.done),        0);
    check("rst_b_run",  0, 32'(bus_b.running),     0);
    check("rst_b_done", 0, 32'(bus_b.done),        0);
`ifdef CLK_COUNTER_CAPTURE_EN
    check("rst_a_cap",  0, 32'(bus_a.cap_value),   0);
    bus_a.capture = 1'b0;
`endif

    // Free-run wrap: 0..9,0 with tc only in the cycle showing 0 after 9
    rst_a_n = 1'b1; bus_a.en = 1'b1; bus_a.up = 1'b1;
    exp_cnt = 4'd0;
    for (int i = 0; i < 22; i++) begin
      exp_tc  = (exp_cnt == 4'd9);
      exp_cnt = (exp_cnt == 4'd9) ? 4'd0 : exp_cnt + 4'd1;
      @(posedge clk);
      #1;
      check("free_cnt", i, 32'(bus_a.counter_out), 32'(exp_cnt));
      check("free_tc",  i, 32'(bus_a.tc),          32'(exp_tc));
    end

    for (int i = 0; i < tbl_a.size(); i++) apply(1'b0, tbl_a[i], i);

`ifdef CLK_COUNTER_CAPTURE_EN
    // Capture samples the pre-update count; reset clears it
    apply(1'b0, mk(1, 0, 1, 1, 6, 0, 6, 0, 1, 0), 100);
    check("cap_idle", 0, 32'(bus_a.cap_value), 0);
    apply(1'b0, mk(1, 1, 1, 0, 0, 0, 7, 0, 1, 0), 101);
    bus_a.capture = 1'b1;
    apply(1'b0, mk(1, 1, 1, 0, 0, 0, 8, 0, 1, 0), 102);
    check("cap_val", 1, 32'(bus_a.cap_value), 7);
    bus_a.capture = 1'b0;
    apply(1'b0, mk(1, 1, 1, 0, 0, 0, 9, 0, 1, 0), 103);
    check("cap_hold", 2, 32'(bus_a.cap_value), 7);
    bus_a.capture = 1'b1;
    apply(1'b0, mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0), 104);
    check("cap_rst", 3, 32'(bus_a.cap_value), 0);
    bus_a.capture = 1'b0;
`endif

    for (int i = 0; i < tbl_b.size(); i++) apply(1'b1, tbl_b[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
